xnor_pattern_matcher: RTL and testbench

//  Serial-bit pattern matcher that follows the XNOR gate cells in the logic library.

---
 rtl/xnor_match_pkg.sv | 18 +
 rtl/xnor_pattern_matcher_if.sv | 26 ++
 rtl/xnor_agree_count.sv | 27 ++
 rtl/xnor_pattern_matcher.sv | 126 ++++++++++++
 tb/tb_xnor_pattern_matcher.sv | 305 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/xnor_match_pkg.sv
// Shared types and helpers for the XNOR serial pattern matcher.
package xnor_match_pkg;

   typedef enum logic [1:0] {
      FILL,
      TRACK,
      HOLD
   } state_t;

   localparam int DEFAULT_WIDTH = 8;
   localparam int SCORE_W       = $clog2(DEFAULT_WIDTH + 1);

   // Bits needed to hold an agreement count of 0..width.
   function automatic int score_width(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/xnor_pattern_matcher_if.sv
// Serial-bit input stream and match-event output stream of the matcher.
// master: bit source / match consumer side. slave: the matcher itself.
interface xnor_pattern_matcher_if
   import xnor_match_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   localparam int SW = score_width(WIDTH);

   logic          in_valid;
   logic          in_ready;
   logic          in_bit;
   logic          out_valid;
   logic          out_ready;
   logic [SW-1:0] out_score;

   modport master (
      output in_valid, in_bit, out_ready,
      input  in_ready, out_valid, out_score
   );

   modport slave (
      input  in_valid, in_bit, out_ready,
      output in_ready, out_valid, out_score
   );
endinterface

// File: rtl/xnor_agree_count.sv
// Combinational agreement counter: one xnor cell per bit, then a popcount.
module xnor_agree_count
   import xnor_match_pkg::*;
#(
   parameter  int WIDTH = DEFAULT_WIDTH,
   localparam int SW    = score_width(WIDTH)
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [SW-1:0]    score
);

   logic [WIDTH-1:0] agree;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      xnor u_xnor (agree[i], a[i], b[i]);
   end

   // Popcount of the agreeing bit positions.
   always_comb begin
      score = '0;
      for (int i = 0; i < WIDTH; i++) begin
         score = score + SW'(agree[i]);
      end
   end

endmodule

// File: rtl/xnor_pattern_matcher.sv
// Serial XNOR pattern matcher: slides a WIDTH-bit window over the input
// stream and reports every window whose agreement score reaches THRESH.
// Optional feature macro: XNOR_MATCH_PATTERN_LOAD_EN adds a runtime
// pattern load port (pat_load / pat_data).
module xnor_pattern_matcher
   import xnor_match_pkg::*;
#(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] PATTERN = 8'b1011_0010,
   parameter int               THRESH  = WIDTH,
   parameter int               CNT_W   = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
`ifdef XNOR_MATCH_PATTERN_LOAD_EN
   input  logic                 pat_load,
   input  logic [WIDTH-1:0]     pat_data,
`endif
   xnor_pattern_matcher_if.slave bus,
   output logic [CNT_W-1:0]     match_cnt
);

   localparam int SW = score_width(WIDTH);

   state_t           state, state_next;
   logic [WIDTH-1:0] sr, sr_next;
   logic [SW-1:0]    fill, fill_next;
   logic [SW-1:0]    score, out_score;
   logic [WIDTH-1:0] pattern;
   logic             in_fire, out_fire, hit, capture;

   assign bus.in_ready  = (state != HOLD) | bus.out_ready;
   assign bus.out_valid = (state == HOLD);
   assign bus.out_score = out_score;

   assign in_fire  = bus.in_valid & bus.in_ready;
   assign out_fire = bus.out_valid & bus.out_ready;
   assign sr_next  = {sr[WIDTH-2:0], bus.in_bit};

   xnor_agree_count #(.WIDTH(WIDTH)) u_agree (
      .a     (sr_next),
      .b     (pattern),
      .score (score)
   );

   assign hit = (score >= SW'(THRESH));

   // Next-state logic: fill the window, then evaluate every accepted bit.
   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred.
      state_next = state;
      fill_next  = fill;
      capture    = 1'b0;
      unique case (state)
         FILL: begin
            if (in_fire) begin
               if (fill == SW'(WIDTH - 1)) begin
                  fill_next  = '0;
                  capture    = hit;
                  state_next = hit ? HOLD : TRACK;
               end else begin
                  fill_next = fill + SW'(1);
               end
            end
         end
         TRACK: begin
            if (in_fire && hit) begin
               capture    = 1'b1;
               state_next = HOLD;
            end
         end
         HOLD: begin
            if (out_fire) begin
               capture    = in_fire & hit;
               state_next = (in_fire && hit) ? HOLD : TRACK;
            end
         end
         default: state_next = FILL;
      endcase
   end

   // State, window, fill counter and captured score; clr flushes the stream path.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (rst) begin
         state     <= FILL;
         sr        <= '0;
         fill      <= '0;
         out_score <= '0;
      end else if (clr) begin
         state <= FILL;
         sr    <= '0;
         fill  <= '0;
      end else begin
         state <= state_next;
         fill  <= fill_next;
         if (in_fire) sr        <= sr_next;
         if (capture) out_score <= score;
      end
   end

   // Saturating count of accepted match events; a flushed event is not counted.
   always_ff @(posedge clk) begin
      if (rst) begin
         match_cnt <= '0;
      end else if (!clr && out_fire && (match_cnt != '1)) begin
         match_cnt <= match_cnt + CNT_W'(1);
      end
   end

`ifdef XNOR_MATCH_PATTERN_LOAD_EN
   // Runtime-loadable reference pattern; the current cycle still uses the old one.
   always_ff @(posedge clk) begin
      // NOTE: the pattern register has a reset value; clr deliberately leaves it alone.
      if (rst) begin
         pattern <= PATTERN;
      end else if (pat_load) begin
         pattern <= pat_data;
      end
   end
`else
   assign pattern = PATTERN;
`endif

endmodule

// File: tb/tb_xnor_pattern_matcher.sv
// Self-checking bench for xnor_pattern_matcher. Three instances share one
// stimulus: A (defaults), B (THRESH=7), C (CNT_W=2). A bit-history model
// predicts every output on every cycle; directed checks pin key values.
// Define XNOR_MATCH_PATTERN_LOAD_EN to also exercise the pattern load port.
`timescale 1ns/1ps
module tb_xnor_pattern_matcher;
   import xnor_match_pkg::*;

   localparam int         WIDTH = 8;
   localparam int         SW    = $clog2(WIDTH + 1);
   localparam int         NI    = 3;
   localparam logic [7:0] PAT   = 8'hB2;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst, clr, in_valid, in_bit, out_ready;
`ifdef XNOR_MATCH_PATTERN_LOAD_EN
   logic       pat_load;
   logic [7:0] pat_data;
`endif
   logic [7:0] cnt_a, cnt_b;
   logic [1:0] cnt_c;

   xnor_pattern_matcher_if #(.WIDTH(WIDTH)) bus_a ();
   xnor_pattern_matcher_if #(.WIDTH(WIDTH)) bus_b ();
   xnor_pattern_matcher_if #(.WIDTH(WIDTH)) bus_c ();

   assign bus_a.in_valid = in_valid;  assign bus_a.in_bit = in_bit;  assign bus_a.out_ready = out_ready;
   assign bus_b.in_valid = in_valid;  assign bus_b.in_bit = in_bit;  assign bus_b.out_ready = out_ready;
   assign bus_c.in_valid = in_valid;  assign bus_c.in_bit = in_bit;  assign bus_c.out_ready = out_ready;

   xnor_pattern_matcher #(.WIDTH(WIDTH), .PATTERN(PAT), .THRESH(8), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .clr(clr),
`ifdef XNOR_MATCH_PATTERN_LOAD_EN
      .pat_load(pat_load), .pat_data(pat_data),
`endif
      .bus(bus_a), .match_cnt(cnt_a)
   );

   xnor_pattern_matcher #(.WIDTH(WIDTH), .PATTERN(PAT), .THRESH(7), .CNT_W(8)) dut_b (
      .clk(clk), .rst(rst), .clr(clr),
`ifdef XNOR_MATCH_PATTERN_LOAD_EN
      .pat_load(pat_load), .pat_data(pat_data),
`endif
      .bus(bus_b), .match_cnt(cnt_b)
   );

   xnor_pattern_matcher #(.WIDTH(WIDTH), .PATTERN(PAT), .THRESH(8), .CNT_W(2)) dut_c (
      .clk(clk), .rst(rst), .clr(clr),
`ifdef XNOR_MATCH_PATTERN_LOAD_EN
      .pat_load(pat_load), .pat_data(pat_data),
`endif
      .bus(bus_c), .match_cnt(cnt_c)
   );

   // Observed outputs, widened for uniform comparison.
   logic [31:0] act_ir[NI], act_ov[NI], act_sc[NI], act_cnt[NI];
   assign act_ir[0] = 32'(bus_a.in_ready);  assign act_ov[0] = 32'(bus_a.out_valid);
   assign act_ir[1] = 32'(bus_b.in_ready);  assign act_ov[1] = 32'(bus_b.out_valid);
   assign act_ir[2] = 32'(bus_c.in_ready);  assign act_ov[2] = 32'(bus_c.out_valid);
   assign act_sc[0] = 32'(bus_a.out_score); assign act_cnt[0] = 32'(cnt_a);
   assign act_sc[1] = 32'(bus_b.out_score); assign act_cnt[1] = 32'(cnt_b);
   assign act_sc[2] = 32'(bus_c.out_score); assign act_cnt[2] = 32'(cnt_c);

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   // History of accepted bits since the last flush; the window is the newest
   // WIDTH of them, newest at bit 0. A pending event blocks input unless the
   // consumer is ready in the same cycle.
   int         thr[NI]  = '{8, 7, 8};
   int         cmax[NI] = '{255, 255, 3};
   bit         hist[NI][64];
   int         len[NI];
   bit         pend[NI];
   int         msc[NI];
   int         mcnt[NI];
   logic [7:0] mpat[NI];
   bit         model_ready = 1'b0;

   function automatic int window_score(input int k);
      int s = 0;
      for (int i = 0; i < WIDTH; i++) begin
         if (hist[k][(len[k] - 1 - i) % 64] == mpat[k][i]) s++;
      end
      return s;
   endfunction

   always @(posedge clk) begin
      for (int k = 0; k < NI; k++) begin
         bit ir, fin, fout;
         int s;
         ir   = !pend[k] || out_ready;
         fin  = in_valid && ir;
         fout = pend[k] && out_ready;
         if (rst) begin
            len[k] = 0; pend[k] = 0; msc[k] = 0; mcnt[k] = 0; mpat[k] = PAT;
         end else if (clr) begin
            len[k] = 0; pend[k] = 0;
         end else begin
            if (fout) begin
               pend[k] = 0;
               if (mcnt[k] < cmax[k]) mcnt[k]++;
            end
            if (fin) begin
               hist[k][len[k] % 64] = in_bit;
               len[k]++;
               if (len[k] >= WIDTH) begin
                  s = window_score(k);
                  if (s >= thr[k]) begin
                     pend[k] = 1;
                     msc[k]  = s;
                  end
               end
            end
         end
`ifdef XNOR_MATCH_PATTERN_LOAD_EN
         if (!rst && pat_load) mpat[k] = pat_data;
`endif
      end
      if (rst) model_ready = 1'b1;
   end

   // Per-cycle comparison of every instance against the model.
   always @(negedge clk) begin
      if (model_ready) begin
         for (int k = 0; k < NI; k++) begin
            check($sformatf("inst%0d in_ready", k), act_ir[k], 32'(!pend[k] || out_ready));
            check($sformatf("inst%0d out_valid", k), act_ov[k], 32'(pend[k]));
            check($sformatf("inst%0d out_score", k), act_sc[k], msc[k]);
            check($sformatf("inst%0d match_cnt", k), act_cnt[k], mcnt[k]);
         end
      end
   end

   // Pulse counter for instance A's out_valid.
   bit count_en = 1'b0;
   int pulses   = 0;
   always @(negedge clk) if (count_en && act_ov[0] == 1) pulses++;

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_bits(input logic [7:0] v, input int n);
      for (int i = n - 1; i >= 0; i--) begin
         in_valid = 1'b1;
         in_bit   = v[i];
         step();
      end
      in_valid = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] v);
      send_bits(v, 8);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_bit = 1'b0; out_ready = 1'b1;
`ifdef XNOR_MATCH_PATTERN_LOAD_EN
      pat_load = 1'b0; pat_data = '0;
`endif
      step();
      step();
      check("reset out_valid", act_ov[0], 0);
      check("reset out_score", act_sc[0], 0);
      check("reset match_cnt", act_cnt[0], 0);
      check("reset in_ready", act_ir[0], 1);
      rst = 1'b0;

      // Exact pattern: one-cycle event right after the 8th bit.
      send_byte(8'hB2);
      check("t1 out_valid", act_ov[0], 1);
      check("t1 out_score", act_sc[0], 8);
      check("t1 cnt before fire", act_cnt[0], 0);
      step();
      check("t1 single pulse", act_ov[0], 0);
      check("t1 match_cnt", act_cnt[0], 1);

      // Back-pressure: event held, input stalled, released by out_ready.
      out_ready = 1'b0;
      send_byte(8'hB2);
      check("t3 out_valid", act_ov[0], 1);
      check("t3 out_score", act_sc[0], 8);
      check("t3 in_ready low", act_ir[0], 0);
      in_valid = 1'b1;
      in_bit   = 1'b1;
      step();
      step();
      check("t3 held out_valid", act_ov[0], 1);
      check("t3 held out_score", act_sc[0], 8);
      check("t3 held match_cnt", act_cnt[0], 1);
      out_ready = 1'b1;
      #1;
      check("t3 in_ready released", act_ir[0], 1);
      step();
      in_valid = 1'b0;
      check("t3 out_valid after fire", act_ov[0], 0);
      check("t3 match_cnt", act_cnt[0], 2);

      // Threshold 7 accepts one disagreeing bit; exact match rejects it.
      do_reset();
      send_byte(8'hB3);
      check("t2 exact no match", act_ov[0], 0);
      check("t2 thresh7 out_valid", act_ov[1], 1);
      check("t2 thresh7 out_score", act_sc[1], 7);
      check("t2 model score pin", msc[1], 7);
      step();

      // Continuous 0xB2B2: events after bit 8 and bit 16 only.
      do_reset();
      pulses   = 0;
      count_en = 1'b1;
      send_byte(8'hB2);
      send_byte(8'hB2);
      check("t4 second match", act_ov[0], 1);
      step();
      count_en = 1'b0;
      check("t4 pulse count", pulses, 2);
      check("t4 match_cnt", act_cnt[0], 2);

      // clr after 5 bits drops the window and the bit presented with clr.
      do_reset();
      send_bits(8'b0001_0110, 5);
      clr = 1'b1; in_valid = 1'b1; in_bit = 1'b0;
      step();
      clr = 1'b0; in_valid = 1'b0;
      pulses   = 0;
      count_en = 1'b1;
      send_bits(8'b0000_0010, 3);
      check("t5 no match after clr", act_ov[0], 0);
      send_byte(8'hB2);
      check("t5 resend match", act_ov[0], 1);
      check("t5 resend score", act_sc[0], 8);
      step();
      count_en = 1'b0;
      check("t5 pulse count", pulses, 1);
      check("t5 match_cnt", act_cnt[0], 1);

      // clr drops a pending event without counting it.
      out_ready = 1'b0;
      send_byte(8'hB2);
      check("t5 pending before clr", act_ov[0], 1);
      clr = 1'b1;
      step();
      clr = 1'b0;
      check("t5 clr drops event", act_ov[0], 0);
      check("t5 clr keeps cnt", act_cnt[0], 1);

      // rst mid-HOLD clears everything.
      send_byte(8'hB2);
      check("rst pending before", act_ov[0], 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("rst mid-hold out_valid", act_ov[0], 0);
      check("rst mid-hold match_cnt", act_cnt[0], 0);
      out_ready = 1'b1;

      // Saturating 2-bit counter: 0,1,2,3,3 observed at each new match.
      do_reset();
      for (int m = 0; m < 5; m++) begin
         send_byte(8'hB2);
         check($sformatf("t6 cnt2 at match %0d", m), act_cnt[2], (m < 3) ? m : 3);
      end
      step();
      check("t6 cnt2 saturated", act_cnt[2], 3);
      check("t6 cnt8 total", act_cnt[0], 5);

`ifdef XNOR_MATCH_PATTERN_LOAD_EN
      // Runtime pattern load of all-ones.
      do_reset();
      pat_data = 8'hFF;
      pat_load = 1'b1;
      step();
      pat_load = 1'b0;
      send_byte(8'hFF);
      check("load out_valid", act_ov[0], 1);
      check("load out_score", act_sc[0], 8);
      step();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
